// File: rtl/tag_mem_pkg.sv
// tag_mem_pkg -- shared types for the tag memory arbiter.
//   clr_state_e : clear sweep states (IDLE, CLEAR, DONE)
//   sel_e       : which source owns the RAM port this cycle
//   clog2_min1  : counter width helper that never returns zero
package tag_mem_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_e;

  typedef enum logic [1:0] {SEL_NONE, SEL_A, SEL_B, SEL_CLR} sel_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tag_rr_arb2.sv
// tag_rr_arb2 -- 2-way round-robin arbiter.
//   clk, rst_i : clock, async active-high reset
//   en         : arbitration allowed this cycle (low -> no grants)
//   req[1:0]   : requests, bit 0 = port A, bit 1 = port B
//   gnt[1:0]   : one-hot (or zero) combinational grant
// With both requesting, the port that did not win last time wins; the
// history bit only moves when a grant is actually issued.
module tag_rr_arb2 (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_b;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last_b ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i)      last_b <= 1'b0;
    else if (|gnt)  last_b <= gnt[1];
  end

endmodule

// File: rtl/tag_mem_arbiter.sv
// tag_mem_arbiter -- shares one tag RAM (one tag bit per data byte) between
// a load/store port A (read/write), a fetch port B (read-only) and an
// optional whole-RAM clear engine.
//   clk, rst_i                    : clock, async active-high reset
//   a_req_i/a_gnt_o, a_addr_i,
//   a_we_i, a_be_i, a_wdata_i     : port A request, combinational grant
//   a_rvalid_o, a_rdata_o         : port A response, one cycle after grant
//   b_req_i/b_gnt_o, b_addr_i     : port B read request
//   b_rvalid_o, b_rdata_o         : port B response
//   clr_start_i, clr_busy_o,
//   clr_done_o                    : clear sweep control/status
//   ram_*                         : RAM port, 1-cycle registered read
// Build option: define TAG_CLEAR_EN to include the clear engine; without it
// clr_start_i is ignored and the busy/done flags are tied low.
module tag_mem_arbiter
  import tag_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 32768
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    a_req_i,
  output logic                    a_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic                    a_we_i,
  input  logic [DATA_WIDTH/8-1:0] a_be_i,
  input  logic                    a_wdata_i,
  output logic                    a_rvalid_o,
  output logic [DATA_WIDTH/8-1:0] a_rdata_o,
  input  logic                    b_req_i,
  output logic                    b_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  output logic                    b_rvalid_o,
  output logic [DATA_WIDTH/8-1:0] b_rdata_o,
  input  logic                    clr_start_i,
  output logic                    clr_busy_o,
  output logic                    clr_done_o,
  output logic                    ram_en_o,
  output logic                    ram_we_o,
  output logic                    ram_wdata_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH/8-1:0] ram_rdata_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int ROWS  = NUM_WORDS / BE_W;
  localparam int ROW_W = clog2_min1(ROWS);
  localparam int BE_SH = $clog2(BE_W);

  logic [1:0]       gnt;
  logic [1:0]       rvld_q;   // [0] = A, [1] = B response due this cycle
  logic             clr_act;
  logic             arb_en;
  logic [ROW_W-1:0] row_q;
  sel_e             sel;

`ifdef TAG_CLEAR_EN
  clr_state_e       state_q, state_d;
  logic [ROW_W-1:0] row_d;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  // Start is only honoured in IDLE; the sweep stops at the last row
  // rather than wrapping, so DONE is reached after exactly ROWS writes.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      IDLE:  if (clr_start_i) begin
               state_d = CLEAR;
               row_d   = '0;
             end
      CLEAR: if (row_q == ROW_W'(ROWS - 1)) state_d = DONE;
             else                           row_d   = row_q + 1'b1;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign clr_act    = (state_q == CLEAR);
  assign clr_busy_o = clr_act;
  assign clr_done_o = (state_q == DONE);
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start_i;
  assign row_q      = '0;
  assign clr_act    = 1'b0;
  assign clr_busy_o = 1'b0;
  assign clr_done_o = 1'b0;
`endif

  // Grants are held off during reset so every output reads zero there.
  assign arb_en = !rst_i && !clr_act;

  tag_rr_arb2 u_arb (
    .clk   (clk),
    .rst_i (rst_i),
    .en    (arb_en),
    .req   ({b_req_i, a_req_i}),
    .gnt   (gnt)
  );

  assign a_gnt_o = gnt[0];
  assign b_gnt_o = gnt[1];

  always_comb begin
    sel = SEL_NONE;
    if (clr_act)     sel = SEL_CLR;
    else if (gnt[0]) sel = SEL_A;
    else if (gnt[1]) sel = SEL_B;
  end

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_wdata_o = 1'b0;
    ram_addr_o  = '0;
    ram_be_o    = '0;
    case (sel)
      SEL_A: begin
        ram_en_o    = 1'b1;
        ram_we_o    = a_we_i;
        ram_wdata_o = a_wdata_i;
        ram_addr_o  = a_addr_i;
        ram_be_o    = a_be_i;
      end
      SEL_B: begin
        ram_en_o   = 1'b1;
        ram_addr_o = b_addr_i;
      end
      SEL_CLR: begin
        ram_en_o   = 1'b1;
        ram_we_o   = 1'b1;
        ram_addr_o = ADDR_WIDTH'(row_q) << BE_SH;
        ram_be_o   = '1;
      end
      default: ;
    endcase
  end

  // Response tracking is independent of the clear FSM, so a grant issued
  // the cycle before a sweep starts still gets its response.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) rvld_q <= 2'b00;
    else       rvld_q <= gnt;
  end

  assign a_rvalid_o = rvld_q[0];
  assign b_rvalid_o = rvld_q[1];
  assign a_rdata_o  = rvld_q[0] ? ram_rdata_i : '0;
  assign b_rdata_o  = rvld_q[1] ? ram_rdata_i : '0;

endmodule

// File: tb/tb_tag_mem_arbiter.sv
// tb_tag_mem_arbiter -- random and directed stimulus for tag_mem_arbiter,
// checked every cycle against a behavioural model of the tag memory,
// round-robin rule and clear sweep. Directed sections depend on
// TAG_CLEAR_EN the same way the design does.
module tb_tag_mem_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int NW   = 64;
  localparam int BE   = DW / 8;
  localparam int ROWS = NW / BE;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          a_req_i, a_gnt_o, a_we_i, a_wdata_i, a_rvalid_o;
  logic [AW-1:0] a_addr_i;
  logic [BE-1:0] a_be_i, a_rdata_o;
  logic          b_req_i, b_gnt_o, b_rvalid_o;
  logic [AW-1:0] b_addr_i;
  logic [BE-1:0] b_rdata_o;
  logic          clr_start_i, clr_busy_o, clr_done_o;
  logic          ram_en_o, ram_we_o, ram_wdata_o;
  logic [AW-1:0] ram_addr_o;
  logic [BE-1:0] ram_be_o, ram_rdata_i;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tag_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .rst_i(rst_i),
    .a_req_i(a_req_i), .a_gnt_o(a_gnt_o), .a_addr_i(a_addr_i), .a_we_i(a_we_i),
    .a_be_i(a_be_i), .a_wdata_i(a_wdata_i), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o),
    .b_req_i(b_req_i), .b_gnt_o(b_gnt_o), .b_addr_i(b_addr_i),
    .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o),
    .clr_start_i(clr_start_i), .clr_busy_o(clr_busy_o), .clr_done_o(clr_done_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
    .ram_addr_o(ram_addr_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
  );

  // Tag RAM: registered read-first, per-byte tag write enables.
  logic [BE-1:0] mem [ROWS];
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_rdata_i <= mem[ram_addr_o[5:2]];
      if (ram_we_o)
        for (int i = 0; i < BE; i++)
          if (ram_be_o[i]) mem[ram_addr_o[5:2]][i] <= ram_wdata_o;
    end
  end

  // Reference model state.
  logic [BE-1:0] mm [ROWS];
  bit            m_last_b;   // B won the most recent grant
  int            clr_left;   // rows still to clear
  bit            done_due;
  bit            pa, pb;
  logic [BE-1:0] pa_d, pb_d;

  // Observations from the latest step, for directed checks and the driver.
  bit            o_ag, o_bg, o_busy, o_done;
  logic [BE-1:0] o_ard;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int row_of(input logic [AW-1:0] a);
    return int'(a) / BE;
  endfunction

  // One clock: check at the falling edge, advance the model, return just
  // after the rising edge so the caller can drive the next cycle.
  task automatic step();
    bit clearing, ga, gb, was_done;
    int crow;
    @(negedge clk);
    was_done = done_due;
    clearing = (clr_left > 0) && !rst_i;
    crow     = ROWS - clr_left;
    ga = 1'b0;
    gb = 1'b0;
    if (!rst_i && !clearing) begin
      if (a_req_i && b_req_i) begin
        if (m_last_b) ga = 1'b1;
        else          gb = 1'b1;
      end else begin
        ga = a_req_i;
        gb = b_req_i;
      end
    end
    chk("a_gnt", a_gnt_o, ga);
    chk("b_gnt", b_gnt_o, gb);
    chk("a_rvalid", a_rvalid_o, pa && !rst_i);
    chk("a_rdata", a_rdata_o, (pa && !rst_i) ? pa_d : '0);
    chk("b_rvalid", b_rvalid_o, pb && !rst_i);
    chk("b_rdata", b_rdata_o, (pb && !rst_i) ? pb_d : '0);
    chk("clr_busy", clr_busy_o, clearing);
    chk("clr_done", clr_done_o, was_done && !rst_i);
    chk("ram_en", ram_en_o, ga || gb || clearing);
    if (ga) begin
      chk("ram_addr_a", ram_addr_o, a_addr_i);
      chk("ram_we_a", ram_we_o, a_we_i);
      chk("ram_be_a", ram_be_o, a_be_i);
      chk("ram_wdata_a", ram_wdata_o, a_wdata_i);
    end else if (gb) begin
      chk("ram_addr_b", ram_addr_o, b_addr_i);
      chk("ram_we_b", ram_we_o, 1'b0);
      chk("ram_be_b", ram_be_o, '0);
    end else if (clearing) begin
      chk("ram_addr_clr", ram_addr_o, crow * BE);
      chk("ram_we_clr", ram_we_o, 1'b1);
      chk("ram_be_clr", ram_be_o, {BE{1'b1}});
      chk("ram_wdata_clr", ram_wdata_o, 1'b0);
    end
    o_ag = a_gnt_o; o_bg = b_gnt_o; o_busy = clr_busy_o; o_done = clr_done_o;
    o_ard = a_rdata_o;

    if (rst_i) begin
      m_last_b = 1'b0; clr_left = 0; done_due = 1'b0; pa = 1'b0; pb = 1'b0;
    end else begin
      pa = ga;
      pb = gb;
      if (ga) pa_d = mm[row_of(a_addr_i)];
      if (gb) pb_d = mm[row_of(b_addr_i)];
      if (ga && a_we_i)
        for (int i = 0; i < BE; i++)
          if (a_be_i[i]) mm[row_of(a_addr_i)][i] = a_wdata_i;
      if (ga) m_last_b = 1'b0;
      if (gb) m_last_b = 1'b1;
      done_due = 1'b0;
      if (clearing) begin
        mm[crow] = '0;
        clr_left--;
        done_due = (clr_left == 0);
      end
`ifdef TAG_CLEAR_EN
      else if (!was_done && clr_start_i) clr_left = ROWS;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nbusy, ndone;
    rst_i = 1'b1;
    a_req_i = 0; a_addr_i = '0; a_we_i = 0; a_be_i = '0; a_wdata_i = 0;
    b_req_i = 0; b_addr_i = '0; clr_start_i = 0;
    ram_rdata_i = '0;
    m_last_b = 0; clr_left = 0; done_due = 0; pa = 0; pb = 0; pa_d = '0; pb_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      mem[r] = BE'($urandom);
      mm[r]  = mem[r];
    end
    mem[4] = 4'b1010; mm[4] = 4'b1010;
    mem[2] = 4'b0000; mm[2] = 4'b0000;

    // Reset with requests present: everything must stay quiet.
    a_req_i = 1; b_req_i = 1; clr_start_i = 1;
    step();
    step();
    a_req_i = 0; b_req_i = 0; clr_start_i = 0;
    rst_i = 0;
    step();

    // Lone A read of row 4.
    a_req_i = 1; a_addr_i = 8'h10; a_we_i = 0;
    step();
    chk("r036_gnt", o_ag, 1'b1);
    a_req_i = 0;
    step();
    chk("r036_rdata", o_ard, 4'b1010);

    // Byte-enabled tag write then read back.
    a_req_i = 1; a_addr_i = 8'h08; a_we_i = 1; a_be_i = 4'b0101; a_wdata_i = 1;
    step();
    a_we_i = 0;
    step();
    a_req_i = 0;
    step();
    chk("r037_rdata", o_ard, 4'b0101);

    // Both requesting continuously: B first, then alternate.
    a_req_i = 1; a_addr_i = 8'h20; b_req_i = 1; b_addr_i = 8'h30;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("r038_gnt%0d", k), {o_ag, o_bg}, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    a_req_i = 0; b_req_i = 0;
    step();

`ifdef TAG_CLEAR_EN
    // Full sweep with a same-cycle A request, a re-start mid-sweep and
    // A held requesting throughout.
    a_req_i = 1; a_addr_i = 8'h3C; clr_start_i = 1;
    step();
    chk("r027_gnt", o_ag, 1'b1);
    clr_start_i = 0;
    nbusy = 0; ndone = 0;
    for (int k = 0; k < 20; k++) begin
      clr_start_i = (k == 3 || k == 16);
      step();
      nbusy += int'(o_busy);
      ndone += int'(o_done);
    end
    clr_start_i = 0;
    chk("r039_busy_cycles", nbusy, ROWS);
    chk("r039_done_pulses", ndone, 1);
    a_req_i = 0;
    step();
    chk("r039_rdata", o_ard, 4'b0000);

    // Reset in the middle of a sweep.
    clr_start_i = 1;
    step();
    clr_start_i = 0;
    for (int k = 0; k < 7; k++) begin
      clr_start_i = (k == 2);
      step();
    end
    clr_start_i = 0;
    rst_i = 1;
    step();
    rst_i = 0;
    nbusy = 0; ndone = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      nbusy += int'(o_busy);
      ndone += int'(o_done);
    end
    chk("r040_busy_cycles", nbusy, 0);
    chk("r040_done_pulses", ndone, 0);
`else
    // Clear request is ignored when the engine is not built.
    clr_start_i = 1; a_req_i = 1; a_addr_i = 8'h04; a_we_i = 0;
    step();
    chk("r041_gnt", o_ag, 1'b1);
    chk("r041_busy0", o_busy, 1'b0);
    clr_start_i = 0; a_req_i = 0;
    step();
    chk("r041_busy1", o_busy, 1'b0);
`endif

    // Random traffic: requesters hold until granted.
    for (int c = 0; c < 800; c++) begin
      if (!a_req_i || o_ag) begin
        a_req_i   = ($urandom_range(0, 2) != 0);
        a_addr_i  = AW'($urandom_range(0, NW - 1));
        a_we_i    = 1'($urandom);
        a_be_i    = BE'($urandom);
        a_wdata_i = 1'($urandom);
      end
      if (!b_req_i || o_bg) begin
        b_req_i  = ($urandom_range(0, 2) != 0);
        b_addr_i = AW'($urandom_range(0, NW - 1));
      end
      clr_start_i = ($urandom_range(0, 60) == 0);
      rst_i       = ($urandom_range(0, 300) == 0);
      step();
    end
    rst_i = 0; clr_start_i = 0; a_req_i = 0; b_req_i = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tag_mem_arbiter.md
TAG_MEM_ARBITER -- requirements
Module: tag_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: byte-address width of requesters and RAM.
REQ-002 Parameter DATA_WIDTH, default 32: data word width; BE_W = DATA_WIDTH/8 tag bits per row.
REQ-003 Parameter NUM_WORDS, default 32768: byte capacity; ROWS = NUM_WORDS/BE_W.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 a_req_i / a_gnt_o  in/out  1  data-side (LSU) request / grant.
REQ-007 a_addr_i  in  ADDR_WIDTH; a_we_i  in  1; a_be_i  in  BE_W; a_wdata_i  in  1  (tag bit written to enabled bytes).
REQ-008 a_rvalid_o  out  1; a_rdata_o  out  BE_W  response for port A.
REQ-009 b_req_i / b_gnt_o  in/out  1; b_addr_i  in  ADDR_WIDTH  fetch-side, read-only.
REQ-010 b_rvalid_o  out  1; b_rdata_o  out  BE_W  response for port B.
REQ-011 clr_start_i  in  1  pulse: clear whole tag RAM; clr_busy_o  out  1; clr_done_o  out  1  one-cycle pulse.
REQ-012 ram_en_o, ram_we_o, ram_wdata_o  out  1; ram_addr_o  out  ADDR_WIDTH; ram_be_o  out  BE_W; ram_rdata_i  in  BE_W  (RAM: 1-cycle registered read).

Function
REQ-013 At most one RAM access per cycle; ram_en_o high only in a cycle with a grant or clear write.
REQ-014 Grant is combinational in the request cycle; address/we/be/wdata forwarded to RAM in the same cycle.
REQ-015 Priority: clear engine > round-robin between A and B.
REQ-016 Round-robin: 1-bit last_b flag; both requesting -> grant the port not granted last; flag updates only on grant.
REQ-017 Single requester with RAM free -> granted immediately.
REQ-018 Port B grants always drive ram_we_o=0, ram_be_o=0.
REQ-019 Granted access (read or write) -> that port's rvalid high exactly one cycle later; rdata = ram_rdata_i in that cycle, rdata = 0 otherwise.
REQ-020 Requester holds req/addr until gnt; ungranted requests are not queued internally.
REQ-021 Clear FSM states IDLE -> CLEAR -> DONE -> IDLE.
REQ-022 IDLE + clr_start_i -> CLEAR; row counter = 0; clr_busy_o = 1 from next cycle.
REQ-023 CLEAR: one write per cycle, ram_addr_o = row << log2(BE_W), ram_be_o all ones, ram_wdata_o = 0; a_gnt_o = b_gnt_o = 0.
REQ-024 Row counter width clog2(ROWS); after row ROWS-1 -> DONE; no wrap to row 0.
REQ-025 DONE: clr_done_o = 1 one cycle, clr_busy_o = 0, arbitration resumes same cycle.
REQ-026 clr_start_i while CLEAR or DONE is ignored.
REQ-027 clr_start_i with an A/B request in the same IDLE cycle: request granted this cycle; clear starts next cycle.
REQ-028 Response to a grant issued in the cycle before CLEAR is still delivered.

Reset
REQ-029 rst_i high: FSM IDLE, row counter 0, last_b 0, pending rvalid cleared.
REQ-030 During reset: all gnt, rvalid, rdata, ram_* outputs, clr_busy_o, clr_done_o = 0.
REQ-031 Reset mid-clear aborts the sweep; no clr_done_o pulse; RAM contents not guaranteed.

Configuration
REQ-032 Macro TAG_CLEAR_EN: defined -> clear FSM per REQ-021..028.
REQ-033 Not defined -> no clear FSM; clr_start_i ignored; clr_busy_o, clr_done_o tied 0; pure A/B arbiter.

Structure
REQ-034 Shared package tag_mem_pkg: clear-state enum (IDLE, CLEAR, DONE) and port-select enum (SEL_NONE, SEL_A, SEL_B, SEL_CLR).
REQ-035 One sub-module tag_rr_arb2: 2-way round-robin arbiter (req, gnt, last_b); FSM and datapath stay in top.

Verification
REQ-036 A read 0x0010 alone -> a_gnt_o same cycle; a_rvalid_o next cycle, a_rdata_o = RAM row 4.
REQ-037 A write addr 0x0008, be=4'b0101, wdata=1, then A read 0x0008 -> a_rdata_o = 4'b0101.
REQ-038 A and B request 4 consecutive cycles -> grants alternate B,A,B,A from reset (last_b=0); no rvalid overlaps.
REQ-039 ROWS=16, clr_start_i -> 16 writes rows 0..15, busy 16 cycles, single clr_done_o; later reads return 0.
REQ-040 clr_start_i during CLEAR and rst_i at row 7 -> second start ignored; after reset busy=0, no done pulse.
REQ-041 Build without TAG_CLEAR_EN, pulse clr_start_i with A reading -> A granted normally, clr_busy_o stays 0.
